// File: rtl/transformer_pkg.sv
// Shared types, constants and dot3 arithmetic for the
// model/camera triangle transform sequencer.
package transformer_pkg;

  typedef logic [2:0][31:0] vec3_t;
  typedef vec3_t [2:0] matrix_t;
  typedef vec3_t [2:0] triangle_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MODEL,
    S_MDRAIN,
    S_CAM,
    S_CDRAIN,
    S_DONE
  } state_t;

  typedef struct packed {
    logic [1:0] v;
    logic [1:0] r;
    logic       cam;
  } tag_t;

  localparam logic [31:0] ONE = 32'h0001_0000;
  localparam logic [3:0] LAST_ISSUE = 4'd8;

  localparam matrix_t IDENTITY = {
    {ONE, 32'h0, 32'h0},
    {32'h0, ONE, 32'h0},
    {32'h0, 32'h0, ONE}
  };

  localparam vec3_t ZERO3 = '0;

  // issue index -> {vertex, row}, vertex outer
  function automatic logic [3:0] split_issue(
    input logic [3:0] c
  );
    logic [3:0] vr;
    vr = 4'b0000;
    unique case (c)
      4'd0: vr = {2'd0, 2'd0};
      4'd1: vr = {2'd0, 2'd1};
      4'd2: vr = {2'd0, 2'd2};
      4'd3: vr = {2'd1, 2'd0};
      4'd4: vr = {2'd1, 2'd1};
      4'd5: vr = {2'd1, 2'd2};
      4'd6: vr = {2'd2, 2'd0};
      4'd7: vr = {2'd2, 2'd1};
      4'd8: vr = {2'd2, 2'd2};
      default: vr = 4'b0000;
    endcase
    return vr;
  endfunction

  // Q16.12 operands, Q32.24 products, back to Q16.16
  function automatic logic [31:0] dot3(
    input vec3_t a,
    input vec3_t b
  );
    logic signed [27:0] a0, a1, a2;
    logic signed [27:0] b0, b1, b2;
    logic signed [55:0] p0, p1, p2;
    logic signed [57:0] s;
    logic signed [57:0] sh;
    a0 = a[0][31:4];
    a1 = a[1][31:4];
    a2 = a[2][31:4];
    b0 = b[0][31:4];
    b1 = b[1][31:4];
    b2 = b[2][31:4];
    p0 = 56'(a0) * 56'(b0);
    p1 = 56'(a1) * 56'(b1);
    p2 = 56'(a2) * 56'(b2);
    s  = 58'(p0) + 58'(p1) + 58'(p2);
    sh = s >>> 8;
    return sh[31:0];
  endfunction

endpackage

// File: rtl/transform_dot3_pipe.sv
// Shared dot3 + translation pipe, DOT_LAT stages deep,
// with issue valid and write-back tag riding alongside.
module transform_dot3_pipe
  import transformer_pkg::*;
#(
  parameter int DOT_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        issue_valid,
  input  tag_t        issue_tag,
  input  vec3_t       row,
  input  vec3_t       vec,
  input  logic [31:0] trans,
  output logic        res_valid,
  output tag_t        res_tag,
  output logic [31:0] res
);

  logic        vld [DOT_LAT];
  tag_t        tg  [DOT_LAT];
  logic [31:0] val [DOT_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DOT_LAT; i++) begin
        vld[i] <= 1'b0;
        tg[i]  <= '0;
        val[i] <= '0;
      end
    end else begin
      vld[0] <= issue_valid;
      tg[0]  <= issue_tag;
      val[0] <= dot3(row, vec) + trans;
      for (int i = 1; i < DOT_LAT; i++) begin
        vld[i] <= vld[i-1];
        tg[i]  <= tg[i-1];
        val[i] <= val[i-1];
      end
    end
  end

  assign res_valid = vld[DOT_LAT-1];
  assign res_tag   = tg[DOT_LAT-1];
  assign res       = val[DOT_LAT-1];

endmodule

// File: rtl/transform_sequencer.sv
// Sequences one triangle through model then camera
// transforms on a single shared dot3 pipe.
module transform_sequencer
  import transformer_pkg::*;
#(
  parameter int DOT_LAT = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      in_valid,
  output logic      in_ready,
  input  triangle_t in_tri,
  input  matrix_t   in_model_mtx,
  input  vec3_t     in_model_t,
  input  logic      in_model_valid,
  input  matrix_t   in_cam_mtx,
  input  vec3_t     in_cam_t,
  input  logic      in_cam_valid,
  output logic      out_valid,
  input  logic      out_ready,
  output triangle_t out_tri,
  output logic      busy
);

  localparam logic [3:0] DRAIN_LAST = 4'(DOT_LAT - 1);

  state_t state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic issue;
  logic accept;

  matrix_t   model_mtx, cam_mtx;
  vec3_t     model_t, cam_t;
  triangle_t tri_q, world, out_buf;

  logic [3:0]  vr;
  logic [1:0]  iv, ir;
  logic        use_cam;
  tag_t        itag;
  vec3_t       op_row, op_vec;
  logic [31:0] op_t;

  logic        res_valid;
  tag_t        res_tag;
  logic [31:0] res;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    issue     = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nx = S_MODEL;
          cnt_nx   = '0;
        end
      end
      S_MODEL: begin
        issue = 1'b1;
        if (cnt == LAST_ISSUE) begin
          state_nx = S_MDRAIN;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 4'd1;
        end
      end
      S_MDRAIN: begin
        if (cnt == DRAIN_LAST) begin
          state_nx = S_CAM;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 4'd1;
        end
      end
      S_CAM: begin
        issue = 1'b1;
        if (cnt == LAST_ISSUE) begin
          state_nx = S_CDRAIN;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 4'd1;
        end
      end
      S_CDRAIN: begin
        if (cnt == DRAIN_LAST) begin
          state_nx = S_DONE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 4'd1;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign busy   = (state != S_IDLE);
  assign accept = in_valid && in_ready;

  // operand select: the camera pass reads the world buffer
  assign vr      = split_issue(cnt);
  assign iv      = vr[3:2];
  assign ir      = vr[1:0];
  assign use_cam = (state == S_CAM);
  assign op_row  = use_cam ? cam_mtx[ir] : model_mtx[ir];
  assign op_vec  = use_cam ? world[iv] : tri_q[iv];
  assign op_t    = use_cam ? cam_t[ir] : model_t[ir];
  assign itag    = '{v: iv, r: ir, cam: use_cam};

  transform_dot3_pipe #(
    .DOT_LAT(DOT_LAT)
  ) u_dot3 (
    .clk        (clk),
    .rst_n      (rst_n),
    .issue_valid(issue),
    .issue_tag  (itag),
    .row        (op_row),
    .vec        (op_vec),
    .trans      (op_t),
    .res_valid  (res_valid),
    .res_tag    (res_tag),
    .res        (res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_mtx <= IDENTITY;
      cam_mtx   <= IDENTITY;
      model_t   <= ZERO3;
      cam_t     <= ZERO3;
      tri_q     <= '0;
      world     <= '0;
      out_buf   <= '0;
    end else begin
      if (accept) begin
        tri_q <= in_tri;
        if (in_model_valid) begin
          model_mtx <= in_model_mtx;
          model_t   <= in_model_t;
        end
        if (in_cam_valid) begin
          cam_mtx <= in_cam_mtx;
          cam_t   <= in_cam_t;
        end
      end
      if (res_valid) begin
        if (res_tag.cam) out_buf[res_tag.v][res_tag.r] <= res;
        else             world[res_tag.v][res_tag.r]   <= res;
      end
    end
  end

  assign out_tri = out_buf;

endmodule
